// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch, decode,
// memory, ALU, branch, immediate and jump phases over a shared datapath.
module multicycle_control #(
  parameter bit SUPPORT_SHIFTS = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic [3:0] alu_control_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       pc_en_o,
  output logic       i_or_d_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       zero_ext_o,
  output logic       illegal_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] state_o
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    IMM_EXEC  = 4'd9,
    IMM_WB    = 4'd10,
    JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'd8;
  localparam logic [ALU_W-1:0] ALU_SRA = 4'd9;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS    = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;
  localparam logic [1:0] SRC_B_RT    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;
  localparam logic [1:0] SRC_B_IMM4  = 2'd3;
  localparam logic [1:0] PC_ALU      = 2'd0;
  localparam logic [1:0] PC_ALUOUT   = 2'd1;
  localparam logic [1:0] PC_JUMP     = 2'd2;

  state_t state;
  state_t state_next;

  logic [ALU_W-1:0] funct_alu;
  logic             funct_shift;
  logic             funct_ok;
  logic [ALU_W-1:0] imm_alu;

  // R-type funct decode; shifts become illegal when the shifter is absent
  always_comb begin
    funct_alu   = ALU_AND;
    funct_shift = 1'b0;
    funct_ok    = 1'b1;
    case (funct_i)
      F_ADD: funct_alu = ALU_ADD;
      F_SUB: funct_alu = ALU_SUB;
      F_AND: funct_alu = ALU_AND;
      F_OR:  funct_alu = ALU_OR;
      F_SLT: funct_alu = ALU_SLT;
      F_SLL: begin
        funct_alu   = ALU_SLL;
        funct_shift = 1'b1;
        funct_ok    = SUPPORT_SHIFTS;
      end
      F_SRL: begin
        funct_alu   = ALU_SRL;
        funct_shift = 1'b1;
        funct_ok    = SUPPORT_SHIFTS;
      end
      F_SRA: begin
        funct_alu   = ALU_SRA;
        funct_shift = 1'b1;
        funct_ok    = SUPPORT_SHIFTS;
      end
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    imm_alu = ALU_ADD;
    case (op_i)
      OP_SLTI: imm_alu = ALU_SLT;
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      default: imm_alu = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (op_i)
          OP_LW, OP_SW:                      state_next = MEM_ADDR;
          OP_RTYPE:                          state_next = EXECUTE;
          OP_BEQ, OP_BNE:                    state_next = BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next = IMM_EXEC;
          OP_J:                              state_next = JUMP;
          default:                           state_next = FETCH;
        endcase
      end
      MEM_ADDR:  state_next = (op_i == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_next = MEM_WB;
      EXECUTE:   state_next = funct_ok ? ALU_WB : FETCH;
      IMM_EXEC:  state_next = IMM_WB;
      default:   state_next = FETCH;
    endcase
  end

  // Moore outputs; only the BRANCH pc enable looks at a live input
  always_comb begin
    alu_control_o = ALU_AND;
    alu_src_a_o   = SRC_A_PC;
    alu_src_b_o   = SRC_B_RT;
    pc_src_o      = PC_ALU;
    pc_en_o       = 1'b0;
    i_or_d_o      = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_write_o   = 1'b0;
    zero_ext_o    = 1'b0;
    illegal_o     = 1'b0;
    case (state)
      FETCH: begin
        ir_write_o    = 1'b1;
        alu_src_a_o   = SRC_A_PC;
        alu_src_b_o   = SRC_B_FOUR;
        alu_control_o = ALU_ADD;
        pc_src_o      = PC_ALU;
        pc_en_o       = 1'b1;
      end
      DECODE: begin
        alu_src_a_o   = SRC_A_PC;
        alu_src_b_o   = SRC_B_IMM4;
        alu_control_o = ALU_ADD;
        case (op_i)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_J: illegal_o = 1'b0;
          default:                                 illegal_o = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_o   = SRC_A_RS;
        alu_src_b_o   = SRC_B_IMM;
        alu_control_o = ALU_ADD;
      end
      MEM_READ: i_or_d_o = 1'b1;
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      MEM_WRITE: begin
        i_or_d_o    = 1'b1;
        mem_write_o = 1'b1;
      end
      EXECUTE: begin
        alu_src_b_o = SRC_B_RT;
        if (funct_ok) begin
          alu_control_o = funct_alu;
          alu_src_a_o   = funct_shift ? SRC_A_SHAMT : SRC_A_RS;
        end else begin
          illegal_o = 1'b1;
        end
      end
      ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o   = SRC_A_RS;
        alu_src_b_o   = SRC_B_RT;
        alu_control_o = ALU_SUB;
        pc_src_o      = PC_ALUOUT;
        if (op_i == OP_BEQ)      pc_en_o = zero_i;
        else if (op_i == OP_BNE) pc_en_o = ~zero_i;
      end
      IMM_EXEC: begin
        alu_src_a_o   = SRC_A_RS;
        alu_src_b_o   = SRC_B_IMM;
        alu_control_o = imm_alu;
        zero_ext_o    = (op_i == OP_ANDI) || (op_i == OP_ORI);
      end
      IMM_WB: reg_write_o = 1'b1;
      JUMP: begin
        pc_src_o = PC_JUMP;
        pc_en_o  = 1'b1;
      end
      default: ;
    endcase
    // Architectural side effects are blocked for the whole reset window
    if (rst_i) begin
      pc_en_o     = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
      ir_write_o  = 1'b0;
      illegal_o   = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter SUPPORT_SHIFTS, default 1, meaning: when 0, functs sll/srl/sra are decoded as illegal.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port op_i, input, 6, instruction opcode field, sampled from the instruction register.
REQ-005 SHALL have port funct_i, input, 6, instruction funct field.
REQ-006 SHALL have port zero_i, input, 1, the ALU zero flag.
REQ-007 SHALL have port alu_control_o, output, 4, ALU operation code: 0 AND, 1 OR, 2 ADD, 3 SLL, 6 SUB, 7 SLT, 8 SRL, 9 SRA.
REQ-008 SHALL have ports alu_src_a_o (2 bits: 0 PC, 1 rs, 2 shamt) and alu_src_b_o (2 bits: 0 rt, 1 constant 4, 2 ext imm, 3 ext imm<<2), both outputs.
REQ-009 SHALL have 1-bit outputs pc_en_o, i_or_d_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, zero_ext_o and illegal_o.
REQ-010 SHALL have output pc_src_o, 2 bits: 0 ALU result, 1 ALUOut register, 2 jump target.
REQ-011 SHALL have output state_o, 4 bits, the current state encoding, for debug.

Function
REQ-012 SHALL implement a Moore FSM with encodings FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, IMM_EXEC=9, IMM_WB=10, JUMP=11.
REQ-013 SHALL, in FETCH, assert ir_write_o=1, select alu_src_a=0, alu_src_b=1, alu_control=2, pc_src=0 and pc_en=1, then go to DECODE.
REQ-014 SHALL, in DECODE, select alu_src_a=0, alu_src_b=3, alu_control=2 (branch target into ALUOut), and branch on op_i.
REQ-015 DECODE transitions: lw (100011) or sw (101011) -> MEM_ADDR; R-type (000000) -> EXECUTE; beq (000100) or bne (000101) -> BRANCH; addi (001000), slti (001010), andi (001100), ori (001101) -> IMM_EXEC; j (000010) -> JUMP; any other opcode -> FETCH with illegal_o=1 for that cycle.
REQ-016 SHALL, in MEM_ADDR, use alu_src_a=1, alu_src_b=2, alu_control=2; then go to MEM_READ for lw or MEM_WRITE for sw.
REQ-017 SHALL assert i_or_d_o=1 in MEM_READ (-> MEM_WB) and both i_or_d_o=1 and mem_write_o=1 in MEM_WRITE (-> FETCH).
REQ-018 SHALL, in MEM_WB, assert reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-019 SHALL, in EXECUTE, use alu_src_b=0 and decode funct: add 100000->2, sub 100010->6, and 100100->0, or 100101->1, slt 101010->7; with alu_src_a=1 for these.
REQ-020 SHALL, in EXECUTE when SUPPORT_SHIFTS=1, decode sll 000000->3, srl 000010->8, sra 000011->9 with alu_src_a=2.
REQ-021 SHALL, in EXECUTE on an unsupported funct, assert illegal_o=1 and go to FETCH without writeback; otherwise go to ALU_WB.
REQ-022 SHALL, in ALU_WB, assert reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-023 SHALL, in BRANCH, use alu_src_a=1, alu_src_b=0, alu_control=6 and pc_src=1, then go to FETCH.
REQ-024 BRANCH SHALL drive pc_en_o = zero_i for beq and pc_en_o = !zero_i for bne, combinationally in the same cycle.
REQ-025 SHALL, in IMM_EXEC, use alu_src_a=1 and alu_src_b=2, with alu_control addi->2, slti->7, andi->0, ori->1.
REQ-026 SHALL assert zero_ext_o=1 for andi/ori in IMM_EXEC, and 0 otherwise; IMM_EXEC goes to IMM_WB.
REQ-027 SHALL, in IMM_WB, assert reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-028 SHALL, in JUMP, assert pc_src=2 and pc_en=1, then go to FETCH.
REQ-029 Any output not named for a state SHALL be 0 in that state.
REQ-030 Latency from FETCH to the next FETCH SHALL be: lw 5 cycles, sw/R-type/imm 4, beq/bne/j 3, illegal 2 (or 3 for a bad funct).

Reset
REQ-031 SHALL, while rst_i=1 at a rising edge, load state FETCH regardless of current state, including mid-instruction.
REQ-032 SHALL force pc_en, mem_write, reg_write, ir_write and illegal to 0 whenever rst_i=1.
REQ-033 SHALL begin FETCH outputs on the first cycle after rst_i deasserts, with state_o=0.

Verification
REQ-034 lw (op 100011) after reset -> state_o sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-035 R-type sra (funct 000011): EXECUTE gives alu_control=9 and alu_src_a=2; with SUPPORT_SHIFTS=0 it gives illegal_o=1 and no reg_write.
REQ-036 beq with zero_i=1 -> pc_en=1 and pc_src=1 in BRANCH; bne with zero_i=1 -> pc_en=0.
REQ-037 ori (001101): IMM_EXEC gives alu_control=1 and zero_ext=1; IMM_WB gives reg_write=1 and reg_dst=0.
REQ-038 op 111111 -> illegal_o=1 for one cycle in DECODE, then FETCH.
REQ-039 rst_i pulsed during MEM_WRITE -> state is 0 on the next edge and mem_write=0 while reset is high.
